// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and default geometry for the text-mode GPU.
//
// Contents:
//   TEXT_COLS / TEXT_ROWS : default glyph grid size (80 x 60)
//   cmd_op_e              : command opcodes carried on cmd_op
//   gpu_state_e           : controller FSM states
//   wrap_add              : modular add of two in-range values
//
// Build option: TEXT_MODE_SCROLL_EN adds the CLEAR_ROW state used by scrolling.
package gpu_pkg;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 60;

    typedef enum logic [1:0] {
        OP_STORE      = 2'b00,
        OP_SET_CURSOR = 2'b01,
        OP_DISPLAY    = 2'b10,
        OP_CLEAR      = 2'b11
    } cmd_op_e;

`ifdef TEXT_MODE_SCROLL_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR_ALL,
        ST_CLEAR_ROW
    } gpu_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR_ALL
    } gpu_state_e;
`endif

    // (a + b) mod m, valid when both a and b are already below m.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned m);
        int unsigned s;
        s = a + b;
        if (s >= m) begin
            s = s - m;
        end
        return s;
    endfunction

endpackage

// File: rtl/text_mode_gpu_if.sv
// text_mode_gpu_if: CPU command bus of the text-mode GPU (valid/ready).
//
// Signals:
//   cmd_valid : command present (master -> slave)
//   cmd_ready : slave can accept a command this cycle (slave -> master)
//   cmd_op    : opcode, see gpu_pkg::cmd_op_e (master -> slave)
//   cmd_data  : GLYPH_W-bit payload (master -> slave)
interface text_mode_gpu_if #(
    parameter int GLYPH_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [GLYPH_W-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/text_buffer.sv
// text_buffer: DEPTH x WIDTH glyph RAM, one write port and one registered
// read port. Read-before-write on a same-cell collision. Contents are not
// reset; only the read register is.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr        : read request; re = 0 yields 0 on the next cycle
//   rd_data          : registered read data
module text_buffer #(
    parameter  int DEPTH = 4800,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of mem gives the pre-write value on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (re) begin
            rd_data_q <= mem[raddr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/text_mode_gpu.sv
// text_mode_gpu: text-mode frame-store controller. Takes byte commands over
// a valid/ready bus, maintains a COLS x ROWS glyph buffer plus cursor, and
// serves a registered glyph read port to the scan-out stage.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cmd                 : command bus (text_mode_gpu_if.slave)
//   rd_col, rd_row      : scan-out read address (logical screen row)
//   rd_glyph            : glyph at (rd_row, rd_col), one cycle later
//   cursor_x, cursor_y  : current cursor
//   display_en          : display enable flag
//
// Build option: TEXT_MODE_SCROLL_EN enables scrolling on bottom-right wrap.
module text_mode_gpu
    import gpu_pkg::*;
#(
    parameter  int COLS    = TEXT_COLS,
    parameter  int ROWS    = TEXT_ROWS,
    parameter  int GLYPH_W = 8,
    localparam int CW      = $clog2(COLS),
    localparam int RW      = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    text_mode_gpu_if.slave     cmd,
    input  logic [CW-1:0]      rd_col,
    input  logic [RW-1:0]      rd_row,
    output logic [GLYPH_W-1:0] rd_glyph,
    output logic [CW-1:0]      cursor_x,
    output logic [RW-1:0]      cursor_y,
    output logic               display_en
);

    localparam int              CELLS     = COLS * ROWS;
    localparam int              AW        = $clog2(CELLS);
    localparam logic [AW-1:0]   LAST_CELL = AW'(CELLS - 1);
    localparam logic [CW-1:0]   LAST_COL  = CW'(COLS - 1);
    localparam logic [RW-1:0]   LAST_ROW  = RW'(ROWS - 1);

    gpu_state_e          state_q, state_d;
    logic [CW-1:0]       cursor_x_q, cursor_x_d;
    logic [RW-1:0]       cursor_y_q, cursor_y_d;
    logic                display_en_q, display_en_d;
    logic [AW-1:0]       clr_addr_q, clr_addr_d;
    logic [RW-1:0]       top_row;
    logic [AW-1:0]       clr_last;

    logic                accept;
    logic [6:0]          set_val;
    logic [RW-1:0]       store_prow;
    logic [AW-1:0]       store_addr;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [GLYPH_W-1:0]  wdata;
    logic                rd_in_range;
    logic [RW-1:0]       rd_prow;
    logic [AW-1:0]       raddr;

`ifdef TEXT_MODE_SCROLL_EN
    logic [RW-1:0]       top_row_q, top_row_d;
    logic [AW-1:0]       clr_last_q, clr_last_d;
    assign top_row  = top_row_q;
    assign clr_last = clr_last_q;
`else
    assign top_row  = '0;
    assign clr_last = LAST_CELL;
`endif

    assign cmd.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign set_val       = cmd.cmd_data[6:0];

    // Logical rows are rotated by top_row to find the physical row.
    assign store_prow  = RW'(wrap_add(32'(cursor_y_q), 32'(top_row), ROWS));
    assign store_addr  = AW'(store_prow) * AW'(COLS) + AW'(cursor_x_q);

    assign rd_in_range = (32'(rd_col) < 32'(COLS)) && (32'(rd_row) < 32'(ROWS));
    assign rd_prow     = rd_in_range ? RW'(wrap_add(32'(rd_row), 32'(top_row), ROWS)) : '0;
    assign raddr       = AW'(rd_prow) * AW'(COLS) + AW'(rd_col);

    // Next-state logic: command decode in IDLE, one zero write per cycle
    // while clearing. Both clear states walk clr_addr up to clr_last.
    always_comb begin
        state_d      = state_q;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        display_en_d = display_en_q;
        clr_addr_d   = clr_addr_q;
`ifdef TEXT_MODE_SCROLL_EN
        top_row_d    = top_row_q;
        clr_last_d   = clr_last_q;
`endif
        we           = 1'b0;
        waddr        = store_addr;
        wdata        = cmd.cmd_data;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op_e'(cmd.cmd_op))
                        OP_STORE: begin
                            we = 1'b1;
                            if (cursor_x_q != LAST_COL) begin
                                cursor_x_d = cursor_x_q + 1'b1;
                            end else begin
                                cursor_x_d = '0;
                                if (cursor_y_q != LAST_ROW) begin
                                    cursor_y_d = cursor_y_q + 1'b1;
                                end else begin
`ifdef TEXT_MODE_SCROLL_EN
                                    // The old top physical row becomes the new bottom row.
                                    cursor_y_d = LAST_ROW;
                                    top_row_d  = RW'(wrap_add(32'(top_row_q), 32'd1, ROWS));
                                    clr_addr_d = AW'(top_row_q) * AW'(COLS);
                                    clr_last_d = clr_addr_d + AW'(COLS - 1);
                                    state_d    = ST_CLEAR_ROW;
`else
                                    cursor_y_d = '0;
`endif
                                end
                            end
                        end
                        OP_SET_CURSOR: begin
                            if (cmd.cmd_data[7]) begin
                                cursor_x_d = (32'(set_val) > 32'(COLS - 1)) ? LAST_COL : CW'(set_val);
                            end else begin
                                cursor_y_d = (32'(set_val) > 32'(ROWS - 1)) ? LAST_ROW : RW'(set_val);
                            end
                        end
                        OP_DISPLAY: begin
                            display_en_d = cmd.cmd_data[0];
                        end
                        OP_CLEAR: begin
                            cursor_x_d = '0;
                            cursor_y_d = '0;
                            clr_addr_d = '0;
`ifdef TEXT_MODE_SCROLL_EN
                            top_row_d  = '0;
                            clr_last_d = LAST_CELL;
`endif
                            state_d    = ST_CLEAR_ALL;
                        end
                        default: ;
                    endcase
                end
            end
`ifdef TEXT_MODE_SCROLL_EN
            ST_CLEAR_ALL, ST_CLEAR_ROW: begin
`else
            ST_CLEAR_ALL: begin
`endif
                we    = !rst;
                waddr = clr_addr_q;
                wdata = '0;
                if (clr_addr_q == clr_last) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset aborts whatever is running and restarts a full clear from cell 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR_ALL;
            cursor_x_q   <= '0;
            cursor_y_q   <= '0;
            display_en_q <= 1'b0;
            clr_addr_q   <= '0;
`ifdef TEXT_MODE_SCROLL_EN
            top_row_q    <= '0;
            clr_last_q   <= LAST_CELL;
`endif
        end else begin
            state_q      <= state_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            display_en_q <= display_en_d;
            clr_addr_q   <= clr_addr_d;
`ifdef TEXT_MODE_SCROLL_EN
            top_row_q    <= top_row_d;
            clr_last_q   <= clr_last_d;
`endif
        end
    end

    text_buffer #(
        .DEPTH (CELLS),
        .WIDTH (GLYPH_W)
    ) u_text_buffer (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (rd_in_range),
        .raddr   (raddr),
        .rd_data (rd_glyph)
    );

    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign display_en = display_en_q;

endmodule

// File: tb/tb_text_mode_gpu.sv
// tb_text_mode_gpu: self-checking bench for text_mode_gpu. Keeps a logical
// screen model (2-D array, scroll = shift rows up) and compares cursor,
// display flag, busy lengths and read-port data against it.
// Works with and without TEXT_MODE_SCROLL_EN.
module tb_text_mode_gpu;
    import gpu_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] rd_col;
    logic [5:0] rd_row;
    logic [7:0] rd_glyph;
    logic [6:0] cursor_x;
    logic [5:0] cursor_y;
    logic       display_en;

    text_mode_gpu_if #(.GLYPH_W(8)) cmd_bus ();

    text_mode_gpu #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .GLYPH_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_bus),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_glyph   (rd_glyph),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .display_en (display_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: what the screen shows, in logical coordinates.
    logic [7:0] screen [ROWS][COLS];
    int         mx;
    int         my;
    int         mden;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelBlank();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                screen[r][c] = 8'h00;
    endtask

    task automatic modelStore(input logic [7:0] d);
        screen[my][mx] = d;
        if (mx < COLS - 1) begin
            mx++;
        end else begin
            mx = 0;
            if (my < ROWS - 1) begin
                my++;
            end else begin
`ifdef TEXT_MODE_SCROLL_EN
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++)
                        screen[r][c] = screen[r + 1][c];
                for (int c = 0; c < COLS; c++)
                    screen[ROWS - 1][c] = 8'h00;
                my = ROWS - 1;
`else
                my = 0;
`endif
            end
        end
    endtask

    task automatic modelApply(input logic [1:0] op, input logic [7:0] d);
        int v;
        v = int'(d[6:0]);
        case (op)
            2'b00: modelStore(d);
            2'b01: begin
                if (d[7]) mx = (v > COLS - 1) ? COLS - 1 : v;
                else      my = (v > ROWS - 1) ? ROWS - 1 : v;
            end
            2'b10: mden = int'(d[0]);
            default: begin
                modelBlank();
                mx = 0;
                my = 0;
            end
        endcase
    endtask

    function automatic logic [7:0] expectRead(input int r, input int c);
        if (r >= ROWS || c >= COLS) return 8'h00;
        return screen[r][c];
    endfunction

    // Present a command at a negedge, wait (bounded) for ready, let one
    // rising edge accept it, and return at the following negedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] d, output int waited);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = d;
        waited = 0;
        while (cmd_bus.cmd_ready !== 1'b1 && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("cmd_ready_seen", 32'(cmd_bus.cmd_ready), 32'd1);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        modelApply(op, d);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_cursor_x"}, 32'(cursor_x), 32'(mx));
        checkOutput({tag, "_cursor_y"}, 32'(cursor_y), 32'(my));
        checkOutput({tag, "_display_en"}, 32'(display_en), 32'(mden));
    endtask

    task automatic readCell(input int r, input int c, output logic [7:0] v);
        rd_row = 6'(r);
        rd_col = 7'(c);
        @(negedge clk);
        v = rd_glyph;
    endtask

    task automatic sweepScreen(input string tag);
        logic [7:0] v;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                readCell(r, c, v);
                checkOutput($sformatf("%s_r%0d_c%0d", tag, r, c), 32'(v), 32'(expectRead(r, c)));
            end
        end
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         w;
        int         r;
        int         c;
        int         sel;
        logic [7:0] v;
        logic [7:0] oldv;
        logic [7:0] newv;

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'b00;
        cmd_bus.cmd_data  = 8'h00;
        rd_row = '0;
        rd_col = '0;
        rst    = 1'b1;
        mx = 0; my = 0; mden = 0;
        modelBlank();

        // Step 1: reset state, initial clear length, display enable, blank screen.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        checkOutput("rst_rd_glyph", 32'(rd_glyph), 32'd0);
        checkState("rst");
        rst = 1'b0;
        applyStimulus(OP_DISPLAY, 8'h01, w);
        checkOutput("init_clear_cycles", 32'(w), 32'(CELLS));
        checkState("init_display");
        checkOutput("init_display_const", 32'(display_en), 32'd1);
        sweepScreen("init_zero");

        // Step 2: cursor placement and row-end advance.
        applyStimulus(OP_SET_CURSOR, 8'h80 | 8'd79, w);
        applyStimulus(OP_SET_CURSOR, 8'h05, w);
        applyStimulus(OP_STORE, 8'h41, w);
        applyStimulus(OP_STORE, 8'h42, w);
        checkOutput("t2_cursor_x", 32'(cursor_x), 32'd1);
        checkOutput("t2_cursor_y", 32'(cursor_y), 32'd6);
        readCell(5, 79, v);
        checkOutput("t2_cell_5_79", 32'(v), 32'h41);
        readCell(6, 0, v);
        checkOutput("t2_cell_6_0", 32'(v), 32'h42);

        // Step 3: clamping and bottom-right wrap.
        applyStimulus(OP_SET_CURSOR, 8'hFF, w);
        applyStimulus(OP_SET_CURSOR, 8'h7F, w);
        checkOutput("t3_clamp_x", 32'(cursor_x), 32'd79);
        checkOutput("t3_clamp_y", 32'(cursor_y), 32'd59);
        applyStimulus(OP_STORE, 8'h43, w);
`ifdef TEXT_MODE_SCROLL_EN
        checkOutput("t3_wrap_x", 32'(cursor_x), 32'd0);
        checkOutput("t3_wrap_y", 32'(cursor_y), 32'd59);
        applyStimulus(OP_DISPLAY, 8'h01, w);
        checkOutput("t3_busy_cycles", 32'(w), 32'd80);
        readCell(58, 79, v);
`else
        checkOutput("t3_wrap_x", 32'(cursor_x), 32'd0);
        checkOutput("t3_wrap_y", 32'(cursor_y), 32'd0);
        applyStimulus(OP_DISPLAY, 8'h01, w);
        checkOutput("t3_busy_cycles", 32'(w), 32'd0);
        readCell(59, 79, v);
`endif
        checkOutput("t3_wrapped_cell", 32'(v), 32'h43);
        checkState("t3");

`ifdef TEXT_MODE_SCROLL_EN
        // Step 4: scroll on wrap past the last cell.
        applyStimulus(OP_CLEAR, 8'h00, w);
        applyStimulus(OP_SET_CURSOR, 8'h01, w);
        checkOutput("t4_clear_cycles", 32'(w), 32'(CELLS));
        applyStimulus(OP_SET_CURSOR, 8'h80, w);
        for (int i = 0; i < COLS; i++) applyStimulus(OP_STORE, 8'h31, w);
        applyStimulus(OP_SET_CURSOR, 8'hFF, w);
        applyStimulus(OP_SET_CURSOR, 8'h7F, w);
        applyStimulus(OP_STORE, 8'h5A, w);
        applyStimulus(OP_DISPLAY, 8'h01, w);
        checkOutput("t4_busy_cycles", 32'(w), 32'd80);
        checkOutput("t4_cursor_x", 32'(cursor_x), 32'd0);
        checkOutput("t4_cursor_y", 32'(cursor_y), 32'd59);
        readCell(0, 17, v);
        checkOutput("t4_row0", 32'(v), 32'h31);
        readCell(58, 79, v);
        checkOutput("t4_row58_col79", 32'(v), 32'h5A);
        readCell(59, 40, v);
        checkOutput("t4_row59", 32'(v), 32'h00);
        sweepScreen("t4_screen");
`endif

        // Step 5: randomized command stream against the model.
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            v   = 8'($urandom_range(0, 255));
            if (sel < 6)      applyStimulus(OP_STORE, v, w);
            else if (sel < 9) applyStimulus(OP_SET_CURSOR, v, w);
            else              applyStimulus(OP_DISPLAY, v, w);
            checkState($sformatf("rand%0d", i));
        end
        sweepScreen("rand_screen");
        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 63));
            c = int'($urandom_range(80, 127));
            if (i % 2 == 1) begin
                r = int'($urandom_range(60, 63));
                c = int'($urandom_range(0, 127));
            end
            readCell(r, c, v);
            checkOutput($sformatf("oob_r%0d_c%0d", r, c), 32'(v), 32'(expectRead(r, c)));
        end

        // Step 6: read-before-write on a same-cycle collision.
        applyStimulus(OP_SET_CURSOR, 8'h80 | 8'd20, w);
        applyStimulus(OP_SET_CURSOR, 8'd10, w);
        oldv = expectRead(10, 20);
        newv = oldv ^ 8'hA5;
        rd_row = 6'd10;
        rd_col = 7'd20;
        applyStimulus(OP_STORE, newv, w);
        checkOutput("rbw_old", 32'(rd_glyph), 32'(oldv));
        @(negedge clk);
        checkOutput("rbw_new", 32'(rd_glyph), 32'(newv));

        // Step 7: reset in the middle of a CLEAR restarts the full clear.
        applyStimulus(OP_DISPLAY, 8'h01, w);
        applyStimulus(OP_CLEAR, 8'h00, w);
        checkOutput("clr_cursor_x", 32'(cursor_x), 32'd0);
        checkOutput("clr_cursor_y", 32'(cursor_y), 32'd0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst2_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        checkOutput("rst2_rd_glyph", 32'(rd_glyph), 32'd0);
        checkOutput("rst2_display_en", 32'(display_en), 32'd0);
        rst  = 1'b0;
        mx   = 0;
        my   = 0;
        mden = 0;
        modelBlank();
        checkState("rst2");
        applyStimulus(OP_DISPLAY, 8'h01, w);
        checkOutput("rst2_clear_cycles", 32'(w), 32'(CELLS));
        checkState("rst2_done");
        sweepScreen("rst2_zero");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/text_mode_gpu.md
Name: text_mode_gpu

Overview:
- Parametrised text-mode frame-store controller: accepts byte commands from the CPU, keeps a COLS x ROWS glyph buffer and a cursor, and serves a registered glyph read port to the scan-out/font stage.
- Sits between the CPU interrupt/command bus and the pixel pipeline.
- Replaces the fixed 80x60 edge-triggered store with clocked valid/ready commands, correct cursor wrap, hardware clear, and optional scrolling.

Parameters:
- COLS, 80, glyph columns per row.
- ROWS, 60, glyph rows.
- GLYPH_W, 8, bits per glyph code; equals cmd_data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  2  00 STORE, 01 SET_CURSOR, 10 DISPLAY, 11 CLEAR.
- cmd_data  in  GLYPH_W  command payload.
- rd_col  in  $clog2(COLS)  scan-out read column.
- rd_row  in  $clog2(ROWS)  scan-out read row (logical, i.e. screen row).
- rd_glyph  out  GLYPH_W  glyph at (rd_row, rd_col); registered.
- cursor_x  out  $clog2(COLS)  current cursor column.
- cursor_y  out  $clog2(ROWS)  current cursor row.
- display_en  out  1  display enable flag.

Behaviour:
- Handshake: a command is accepted only in a cycle where cmd_valid && cmd_ready. cmd_ready = (state == IDLE) && !rst. cmd_op and cmd_data are sampled only on accept.
- Reset:
  - cursor_x = 0, cursor_y = 0, display_en = 0, top_row = 0, rd_glyph = 0, cmd_ready = 0.
  - The FSM enters CLEAR_ALL. Reset asserted mid-operation aborts it and restarts CLEAR_ALL from cell 0.
- FSM states:
  - IDLE: accepts commands.
  - CLEAR_ALL: writes 0 to one cell per cycle, addresses 0 .. COLS*ROWS-1, then returns to IDLE. Lasts exactly COLS*ROWS cycles, during which cmd_ready = 0.
  - CLEAR_ROW: exists only with the optional feature.
- STORE:
  - Write cmd_data to physical address prow*COLS + cursor_x, where prow = (cursor_y + top_row) mod ROWS.
  - Cursor advance:
    - If cursor_x < COLS-1: cursor_x++.
    - Otherwise cursor_x = 0 and cursor_y++.
    - If cursor_y was ROWS-1 at that point, cursor_y wraps to 0 (no scroll).
  - One-cycle operation; the block stays in IDLE.
- SET_CURSOR:
  - cmd_data[7] = 1: cursor_x = min(cmd_data[6:0], COLS-1).
  - cmd_data[7] = 0: cursor_y = min(cmd_data[6:0], ROWS-1).
  - Comparisons are unsigned, at full 7-bit width.
- DISPLAY: display_en = cmd_data[0].
- CLEAR:
  - Enter CLEAR_ALL; cursor is set to (0,0) on accept and top_row = 0.
  - The next command is accepted no earlier than COLS*ROWS cycles after accept.
- Read port:
  - rd_glyph is updated one cycle after rd_row/rd_col are presented, from physical row (rd_row + top_row) mod ROWS.
  - The read port is independent of the FSM and keeps serving during clears.
  - A same-cycle write to the same cell returns old data (read-before-write).
  - Out-of-range rd_col/rd_row (≥ COLS/ROWS) returns 0.

Optional Feature:
- TEXT_MODE_SCROLL_EN defined:
  - A STORE that wraps past (COLS-1, ROWS-1) leaves cursor_y = ROWS-1 and sets cursor_x = 0.
  - top_row advances by 1 mod ROWS, so logical row 0 now shows the old row 1.
  - The FSM enters CLEAR_ROW, zeroing the new bottom physical row: COLS cycles with cmd_ready = 0, then IDLE.
- Undefined: top_row is constant 0, the CLEAR_ROW state is absent, and the wrap goes to (0,0).

Decomposition:
- gpu_pkg holds:
  - the cmd_op enum (OP_STORE, OP_SET_CURSOR, OP_DISPLAY, OP_CLEAR);
  - the FSM state enum;
  - default constants TEXT_COLS = 80 and TEXT_ROWS = 60.
- One sub-module, text_buffer:
  - COLS*ROWS x GLYPH_W single-write / single-registered-read RAM;
  - read-before-write;
  - no reset on contents.

Test Plan:
1. Release rst, hold cmd_valid = 1 with OP_DISPLAY -> cmd_ready low for exactly 4800 cycles, then accepted; display_en = 1; every cell reads 0 with 1-cycle latency.
2. SET_CURSOR 0x80|79, SET_CURSOR 0x05, STORE 0x41, STORE 0x42 -> cell (5,79) = 0x41, cell (6,0) = 0x42, cursor = (1,6).
3. SET_CURSOR 0xFF and 0x7F -> cursor clamps to (79,59); STORE 0x43 -> cursor wraps to (0,0) without TEXT_MODE_SCROLL_EN.
4. With TEXT_MODE_SCROLL_EN, fill row 1 with 0x31, cursor at (79,59), STORE 0x5A:
   - logical row 0 reads 0x31, logical row 58 col 79 reads 0x5A, logical row 59 reads 0;
   - cmd_ready low for 80 cycles; cursor = (0,59).
5. Assert rst for 1 cycle 100 cycles into a CLEAR -> cursor (0,0), display_en = 0, full 4800-cycle clear restarts.
6. Read (r,c) in the same cycle as a STORE to (r,c) -> rd_glyph = old value; the next read returns the new value.
